// File: rtl/register_block_pkg.sv
// Shared constants and types for the CPU general-purpose register file.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int BYTE_W   = 8;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/register_block_byte_lane.sv
// Combinational byte-lane helper: merges a byte into a word on the write path
// and zero-extends the low byte on the read path when byte mode is selected.
module reg_byte_lane
  import regfile_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic              byte_mode,
  output logic [DATA_W-1:0] merged_word,
  output logic [DATA_W-1:0] extract_word
);

  // Write merge: byte mode replaces only the low lane, keeping the upper bits.
  always_comb begin
    merged_word = new_word;
    if (byte_mode) begin
      merged_word = {old_word[DATA_W-1:BYTE_W], new_word[BYTE_W-1:0]};
    end
  end

  // Read extract: byte mode returns the low lane zero-extended to a full word.
  always_comb begin
    extract_word = old_word;
    if (byte_mode) begin
      extract_word = {{(DATA_W-BYTE_W){1'b0}}, old_word[BYTE_W-1:0]};
    end
  end

endmodule

// File: rtl/register_block.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write
// port, hard-wired zero register and an optional byte-lane mode.
module register_block
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              regWrite,
  input  logic              byteOperations,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  // Index 0 is never stored; its reads are forced to zero below.
  word_t regs [1:NUM_REGS-1];

  word_t wr_old;
  word_t wr_next;
  word_t rd1_word;
  word_t rd2_word;
  word_t unused_wr_extract;
  word_t unused_rd1_merge;
  word_t unused_rd2_merge;

  // Current contents of the write target, needed to preserve upper bits in byte mode.
  always_comb begin
    wr_old = '0;
    if (write_reg != ZERO_REG) begin
      wr_old = regs[write_reg];
    end
  end

  // Raw word for read port 1, with register 0 reading as zero.
  always_comb begin
    rd1_word = '0;
    if (read_reg1 != ZERO_REG) begin
      rd1_word = regs[read_reg1];
    end
  end

  // Raw word for read port 2, with register 0 reading as zero.
  always_comb begin
    rd2_word = '0;
    if (read_reg2 != ZERO_REG) begin
      rd2_word = regs[read_reg2];
    end
  end

  reg_byte_lane u_wr_lane (
    .old_word     (wr_old),
    .new_word     (write_data),
    .byte_mode    (byteOperations),
    .merged_word  (wr_next),
    .extract_word (unused_wr_extract)
  );

  reg_byte_lane u_rd1_lane (
    .old_word     (rd1_word),
    .new_word     ('0),
    .byte_mode    (byteOperations),
    .merged_word  (unused_rd1_merge),
    .extract_word (read_data1)
  );

  reg_byte_lane u_rd2_lane (
    .old_word     (rd2_word),
    .new_word     ('0),
    .byte_mode    (byteOperations),
    .merged_word  (unused_rd2_merge),
    .extract_word (read_data2)
  );

  // Storage update: async clear dominates; writes to index 0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (regWrite && (write_reg != ZERO_REG)) begin
      regs[write_reg] <= wr_next;
    end
  end

endmodule

// File: tb/tb_register_block.sv
// Directed bench for register_block: stimulus pushes expected read values into
// a scoreboard queue; a separate monitor pops and compares on each strobe.
module tb_register_block;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regWrite;
  logic        byteOperations;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   chk_seq = 0;

  register_block dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_reg1      (read_reg1),
    .read_reg2      (read_reg2),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .regWrite       (regWrite),
    .byteOperations (byteOperations),
    .read_data1     (read_data1),
    .read_data2     (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on every strobe, pop one expectation and compare both ports.
  initial begin
    exp_t e;
    forever begin
      @(chk_seq);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: strobe with empty queue");
      end else begin
        e = exp_q.pop_front();
        total++;
        if (read_data1 !== e.e1) begin
          bad++;
          $display("FAIL %s port1: got %h expected %h", e.name, read_data1, e.e1);
        end
        total++;
        if (read_data2 !== e.e2) begin
          bad++;
          $display("FAIL %s port2: got %h expected %h", e.name, read_data2, e.e2);
        end
      end
    end
  end

  // Present read addresses, queue the expected data and strobe the monitor.
  task automatic check_rd(input logic [4:0] r1, input logic [4:0] r2, input logic bmode,
                          input logic [31:0] e1, input logic [31:0] e2, input string name);
    exp_t e;
    read_reg1      = r1;
    read_reg2      = r2;
    byteOperations = bmode;
    #1;
    e.e1   = e1;
    e.e2   = e2;
    e.name = name;
    exp_q.push_back(e);
    chk_seq = chk_seq + 1;
    #1;
  endtask

  // Apply write inputs on the falling edge and leave them across one rising edge.
  task automatic do_write(input logic [4:0] idx, input logic [31:0] data,
                          input logic bmode, input logic we);
    @(negedge clk);
    write_reg      = idx;
    write_data     = data;
    byteOperations = bmode;
    regWrite       = we;
    @(posedge clk);
    #1;
    regWrite       = 1'b0;
    byteOperations = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    read_reg1      = '0;
    read_reg2      = '0;
    write_reg      = 5'd3;
    write_data     = 32'hAAAA5555;
    regWrite       = 1'b1;
    byteOperations = 1'b0;

    // Reset held with a write pending: reset must win.
    repeat (2) @(posedge clk);
    #1;
    check_rd(5'd0, 5'd1, 1'b0, 32'h0, 32'h0, "reset_0_1");
    check_rd(5'd2, 5'd31, 1'b0, 32'h0, 32'h0, "reset_2_31");
    check_rd(5'd3, 5'd3, 1'b0, 32'h0, 32'h0, "reset_beats_write");
    regWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_rd(5'd3, 5'd31, 1'b0, 32'h0, 32'h0, "after_release");

    // Word write with no bypass before the edge.
    @(negedge clk);
    write_reg  = 5'd2;
    write_data = 32'hDEADBEEF;
    regWrite   = 1'b1;
    check_rd(5'd2, 5'd2, 1'b0, 32'h0, 32'h0, "no_bypass");
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    check_rd(5'd2, 5'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, "word_write");

    // Byte write into the low lane only.
    do_write(5'd2, 32'h000000FF, 1'b1, 1'b1);
    check_rd(5'd2, 5'd0, 1'b0, 32'hDEADBEFF, 32'h0, "byte_write_word_rd");
    check_rd(5'd2, 5'd2, 1'b1, 32'h000000FF, 32'h000000FF, "byte_write_byte_rd");

    // Byte read zero-extends a word with non-zero upper bits.
    do_write(5'd9, 32'h12345A6C, 1'b0, 1'b1);
    check_rd(5'd9, 5'd2, 1'b1, 32'h0000006C, 32'h000000FF, "byte_read_ext");
    check_rd(5'd9, 5'd2, 1'b0, 32'h12345A6C, 32'hDEADBEFF, "word_read_9_2");

    // Register 0 ignores writes.
    do_write(5'd0, 32'hFFFFFFFF, 1'b0, 1'b1);
    check_rd(5'd0, 5'd2, 1'b0, 32'h0, 32'hDEADBEFF, "reg0_write");

    // Write enable low: no change, including with unknown data.
    do_write(5'd7, 32'h0000000F, 1'b0, 1'b0);
    check_rd(5'd7, 5'd7, 1'b0, 32'h0, 32'h0, "we_low");
    do_write(5'd2, 32'hXXXXXXXX, 1'b0, 1'b0);
    check_rd(5'd2, 5'd9, 1'b0, 32'hDEADBEFF, 32'h12345A6C, "we_low_x");
    do_write(5'd7, 32'h0000000F, 1'b0, 1'b1);
    check_rd(5'd7, 5'd7, 1'b0, 32'h0000000F, 32'h0000000F, "we_high");

    // Top index write.
    do_write(5'd31, 32'hCAFEF00D, 1'b0, 1'b1);
    check_rd(5'd31, 5'd30, 1'b0, 32'hCAFEF00D, 32'h0, "reg31");

    // Asynchronous reset between clock edges.
    do_write(5'd5, 32'h12345678, 1'b0, 1'b1);
    check_rd(5'd5, 5'd7, 1'b0, 32'h12345678, 32'h0000000F, "reg5_loaded");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    check_rd(5'd5, 5'd7, 1'b0, 32'h0, 32'h0, "async_reset_5_7");
    check_rd(5'd2, 5'd31, 1'b0, 32'h0, 32'h0, "async_reset_2_31");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_rd(5'd5, 5'd9, 1'b0, 32'h0, 32'h0, "post_async_reset");

    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
